// File: rtl/instruction_fetch_queue_if.sv
// rtl/instruction_fetch_queue_if.sv - source-side and decode-side handshakes of the fetch queue
// master is the environment (instruction source plus decode); slave is the queue itself.
interface instruction_fetch_queue_if #(
  parameter int OPCODE_W  = 3,
  parameter int OPERAND_W = 3,
  parameter int PC_W      = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [OPCODE_W-1:0]  opcode;
  logic [OPERAND_W-1:0] operand;
  logic                 out_valid;
  logic                 out_ready;
  logic [OPCODE_W-1:0]  opcode_if_reg;
  logic [OPERAND_W-1:0] operand_if_reg;
  logic [PC_W-1:0]      pc_if_reg;

  modport master (
    output in_valid, opcode, operand, out_ready,
    input  in_ready, out_valid, opcode_if_reg, operand_if_reg, pc_if_reg
  );

  modport slave (
    input  in_valid, opcode, operand, out_ready,
    output in_ready, out_valid, opcode_if_reg, operand_if_reg, pc_if_reg
  );
endinterface

// File: rtl/instruction_fetch_queue.sv
// rtl/instruction_fetch_queue.sv - PC-tagging instruction FIFO with a registered IF output stage
// Words bypass the FIFO straight into the output register when the FIFO is empty.
module instruction_fetch_queue #(
  parameter int OPCODE_W  = 3,
  parameter int OPERAND_W = 3,
  parameter int PC_W      = 8,
  parameter int DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          init_regs,
  input  logic                          halt_if,
  input  logic                          flush,
  input  logic [PC_W-1:0]               flush_pc,
  output logic [$clog2(DEPTH+2)-1:0]    occupancy,
  instruction_fetch_queue_if.slave      bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = $clog2(DEPTH + 2);
  localparam int W     = OPCODE_W + OPERAND_W + PC_W;

  logic [W-1:0]         mem [DEPTH];
  logic [PTR_W-1:0]     rd_ptr, wr_ptr;
  logic [CNT_W-1:0]     count, count_nxt;
  logic [PC_W-1:0]      fetch_pc;
  logic                 out_valid_q;
  logic [OPCODE_W-1:0]  opcode_q;
  logic [OPERAND_W-1:0] operand_q;
  logic [PC_W-1:0]      pc_q;
  logic                 full, empty, push, load, pop, bypass, fifo_wr, valid_nxt;
  logic [W-1:0]         in_word, head;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign bus.in_ready = !full && !halt_if && !init_regs && !flush && !rst;
  assign push      = bus.in_valid && bus.in_ready;
  assign load      = !init_regs && (!out_valid_q || bus.out_ready);
  assign pop       = load && !empty;
  assign bypass    = load && empty && push;
  assign fifo_wr   = push && !bypass;
  assign valid_nxt = load ? (pop || bypass) : out_valid_q;
  assign count_nxt = count + CNT_W'(fifo_wr) - CNT_W'(pop);
  assign in_word   = {bus.opcode, bus.operand, fetch_pc};
  assign head      = mem[rd_ptr];

  // fifo_wr already implies !rst, !flush and !init_regs through in_ready
  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr] <= in_word;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      out_valid_q <= 1'b0;
      opcode_q    <= '0;
      operand_q   <= '0;
      pc_q        <= '0;
      occupancy   <= '0;
      fetch_pc    <= rst ? '0 : flush_pc;
    end else if (!init_regs) begin
      if (push)    fetch_pc <= fetch_pc + PC_W'(1);
      if (fifo_wr) wr_ptr   <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr   <= rd_ptr + PTR_W'(1);
      count       <= count_nxt;
      out_valid_q <= valid_nxt;
      occupancy   <= OCC_W'(count_nxt) + OCC_W'(valid_nxt);
      if (pop)         {opcode_q, operand_q, pc_q} <= head;
      else if (bypass) {opcode_q, operand_q, pc_q} <= in_word;
    end
  end

  assign bus.out_valid      = out_valid_q;
  assign bus.opcode_if_reg  = opcode_q;
  assign bus.operand_if_reg = operand_q;
  assign bus.pc_if_reg      = pc_q;
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb/tb_instruction_fetch_queue.sv - directed bench for instruction_fetch_queue
module tb_instruction_fetch_queue;
  logic       clk = 1'b0;
  logic       rst, init_regs, halt_if, flush;
  logic [7:0] flush_pc;
  logic [2:0] occupancy;
  int         total = 0;
  int         bad = 0;
  int         acc;

  instruction_fetch_queue_if #(.OPCODE_W(3), .OPERAND_W(3), .PC_W(8)) bus ();

  instruction_fetch_queue #(.OPCODE_W(3), .OPERAND_W(3), .PC_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .init_regs(init_regs), .halt_if(halt_if), .flush(flush),
    .flush_pc(flush_pc), .occupancy(occupancy), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [2:0] opnd, input logic ordy);
    bus.in_valid  = v;
    bus.opcode    = op;
    bus.operand   = opnd;
    bus.out_ready = ordy;
    #1;
  endtask

  initial begin
    rst = 1'b1; init_regs = 1'b0; halt_if = 1'b0; flush = 1'b0; flush_pc = 8'h00;
    drive(1'b0, 3'd0, 3'd0, 1'b0);
    tick(); tick();
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_op", 32'(bus.opcode_if_reg), 0);
    chk("rst_opnd", 32'(bus.operand_if_reg), 0);
    chk("rst_pc", 32'(bus.pc_if_reg), 0);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_inrdy_held", 32'(bus.in_ready), 0);
    rst = 1'b0;
    drive(1'b1, 3'b101, 3'b010, 1'b1);
    chk("rst_inrdy", 32'(bus.in_ready), 1);
    tick();
    chk("first_valid", 32'(bus.out_valid), 1);
    chk("first_op", 32'(bus.opcode_if_reg), 5);
    chk("first_opnd", 32'(bus.operand_if_reg), 2);
    chk("first_pc", 32'(bus.pc_if_reg), 0);
    chk("first_occ", 32'(occupancy), 1);
    drive(1'b0, 3'd0, 3'd0, 1'b1);
    tick();
    chk("first_drained", 32'(bus.out_valid), 0);

    // fill to capacity DEPTH+1 with decode stalled
    rst = 1'b1; tick(); rst = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 3'(~i), 1'b0);
      if (bus.in_ready) acc++;
      tick();
    end
    chk("fill_accepted", 32'(acc), 5);
    chk("fill_occ", 32'(occupancy), 5);
    chk("fill_inrdy", 32'(bus.in_ready), 0);
    drive(1'b1, 3'd0, 3'd0, 1'b1);
    chk("full_no_refill", 32'(bus.in_ready), 0);
    drive(1'b0, 3'd0, 3'd0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk("drain_valid", 32'(bus.out_valid), 1);
      chk("drain_pc", 32'(bus.pc_if_reg), 32'(k));
      chk("drain_op", 32'(bus.opcode_if_reg), 32'(k));
      chk("drain_opnd", 32'(bus.operand_if_reg), 32'((~k) & 7));
      tick();
    end
    chk("drain_empty", 32'(bus.out_valid), 0);
    chk("drain_occ", 32'(occupancy), 0);

    // streaming across the PC wrap
    flush = 1'b1; flush_pc = 8'hFD;
    tick();
    flush = 1'b0;
    for (int j = 0; j < 5; j++) begin
      drive(1'b1, 3'(j), 3'd1, 1'b1);
      chk("burst_inrdy", 32'(bus.in_ready), 1);
      tick();
      chk("burst_valid", 32'(bus.out_valid), 1);
      chk("burst_occ", 32'(occupancy), 1);
      chk("burst_pc", 32'(bus.pc_if_reg), 32'((8'hFD + j) & 8'hFF));
    end
    drive(1'b0, 3'd0, 3'd0, 1'b1);
    tick();

    // flush with three words buffered
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 3'd2, 3'd3, 1'b0);
      tick();
    end
    chk("pre_flush_occ", 32'(occupancy), 3);
    flush = 1'b1; flush_pc = 8'h40;
    drive(1'b1, 3'd7, 3'd7, 1'b0);
    chk("flush_inrdy", 32'(bus.in_ready), 0);
    tick();
    flush = 1'b0;
    chk("flush_valid", 32'(bus.out_valid), 0);
    chk("flush_occ", 32'(occupancy), 0);
    chk("flush_pcreg", 32'(bus.pc_if_reg), 0);
    drive(1'b1, 3'd4, 3'd1, 1'b1);
    tick();
    chk("post_flush_pc", 32'(bus.pc_if_reg), 32'h40);
    chk("post_flush_op", 32'(bus.opcode_if_reg), 4);
    drive(1'b0, 3'd0, 3'd0, 1'b1);
    tick();

    // halt drains the buffer without accepting
    for (int j = 0; j < 2; j++) begin
      drive(1'b1, 3'(j + 1), 3'd0, 1'b0);
      tick();
    end
    chk("halt_pre_occ", 32'(occupancy), 2);
    halt_if = 1'b1;
    drive(1'b1, 3'd7, 3'd7, 1'b1);
    chk("halt_inrdy", 32'(bus.in_ready), 0);
    tick();
    chk("halt_pc2", 32'(bus.pc_if_reg), 32'h42);
    chk("halt_op2", 32'(bus.opcode_if_reg), 2);
    tick(); tick();
    chk("halt_valid", 32'(bus.out_valid), 0);
    chk("halt_occ", 32'(occupancy), 0);
    halt_if = 1'b0;

    // init_regs freezes a pending word
    drive(1'b1, 3'd6, 3'd5, 1'b0);
    tick();
    init_regs = 1'b1;
    drive(1'b1, 3'd1, 3'd1, 1'b1);
    chk("init_inrdy", 32'(bus.in_ready), 0);
    tick(); tick();
    chk("init_valid", 32'(bus.out_valid), 1);
    chk("init_pc", 32'(bus.pc_if_reg), 32'h43);
    chk("init_op", 32'(bus.opcode_if_reg), 6);
    chk("init_occ", 32'(occupancy), 1);
    init_regs = 1'b0;
    drive(1'b0, 3'd0, 3'd0, 1'b1);
    tick();
    chk("init_release", 32'(bus.out_valid), 0);

    // reset while full drops everything
    for (int j = 0; j < 5; j++) begin
      drive(1'b1, 3'd3, 3'd3, 1'b0);
      tick();
    end
    chk("rfull_occ", 32'(occupancy), 5);
    rst = 1'b1;
    drive(1'b1, 3'd3, 3'd3, 1'b0);
    chk("rmid_inrdy", 32'(bus.in_ready), 0);
    tick();
    rst = 1'b0;
    chk("rmid_occ", 32'(occupancy), 0);
    chk("rmid_valid", 32'(bus.out_valid), 0);
    drive(1'b1, 3'd5, 3'd5, 1'b1);
    tick();
    chk("rmid_pc", 32'(bus.pc_if_reg), 0);
    chk("rmid_occ1", 32'(occupancy), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
